// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART transmit subsystem.
package uart_pkg;

    localparam int DIV_W      = 16;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    // Transmit sequencer states: WAIT aligns the frame start to the next bit tick.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Programmable baud tick generator: a clock counter produces the 16x
// oversample tick, and a phase counter over those ticks produces the 1x bit tick.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int P_DIV_W      = DIV_W,
    parameter int P_OVERSAMPLE = OVERSAMPLE
) (
    input  logic               clk,
    input  logic               i_srst,
    input  logic [P_DIV_W-1:0] i_baud_div,
    output logic               o_tick_16x,
    output logic               o_tick_1x
);

    localparam int PHASE_W = $clog2(P_OVERSAMPLE);

    logic [P_DIV_W-1:0] r_count;
    logic [PHASE_W-1:0] r_phase;
    logic [P_DIV_W-1:0] w_limit;
    logic               w_rst_c;
    logic               w_wrap;

    // A divisor of 0 behaves like 1 so the subtraction never underflows.
    assign w_limit = (i_baud_div == '0) ? '0 : (i_baud_div - P_DIV_W'(1));

    // ">=" rather than "==" so that lowering the divisor mid-count ends the
    // period on the next cycle instead of running the counter round to wrap.
    assign w_rst_c = (r_count >= w_limit);
    assign w_wrap  = (r_phase == PHASE_W'(P_OVERSAMPLE - 1));

    // Free-running clock counter, cleared at the end of each 16x period.
    always_ff @(posedge clk) begin
        if (i_srst || w_rst_c) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + P_DIV_W'(1);
        end
    end

    // Oversample phase: counts 16x ticks and wraps once per bit period.
    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_phase <= '0;
        end else if (w_rst_c) begin
            r_phase <= w_wrap ? '0 : (r_phase + PHASE_W'(1));
        end
    end

    // Ticks are held low while in reset even though the count compare may match.
    assign o_tick_16x = w_rst_c & ~i_srst;
    assign o_tick_1x  = o_tick_16x & w_wrap;

endmodule

// File: rtl/uart_tx_fsm.sv
// 8N1 serializer paced by the 1x bit tick; tx line and busy are registered.
module uart_tx_fsm
    import uart_pkg::*;
#(
    parameter int P_DATA_BITS = DATA_BITS
) (
    input  logic                   clk,
    input  logic                   i_srst,
    input  logic                   i_tick_1x,
    input  logic                   i_tx_start,
    input  logic [P_DATA_BITS-1:0] i_tx_data,
    output logic                   o_tx_line,
    output logic                   o_tx_busy
);

    localparam int IDX_W = $clog2(P_DATA_BITS);

    tx_state_t              r_state;
    logic [P_DATA_BITS-1:0] r_shift;
    logic [IDX_W-1:0]       r_bit_idx;
    logic                   r_tx_line;
    logic                   r_busy;

    // Frame sequencer: the byte is latched on accept so later tx_data changes
    // cannot disturb the frame, and tx_start is only looked at in IDLE.
    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx_line <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx_line <= 1'b1;
                    r_busy    <= 1'b0;
                    if (i_tx_start) begin
                        r_shift <= i_tx_data;
                        r_busy  <= 1'b1;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_tick_1x) begin
                        r_tx_line <= 1'b0;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (i_tick_1x) begin
                        r_tx_line <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (i_tick_1x) begin
                        if (r_bit_idx == IDX_W'(P_DATA_BITS - 1)) begin
                            r_tx_line <= 1'b1;
                            r_state   <= ST_STOP;
                        end else begin
                            r_tx_line <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (i_tick_1x) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_tx_line <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tx_line = r_tx_line;
    assign o_tx_busy = r_busy;

endmodule

// File: rtl/uart_tx_baud_top.sv
// UART transmit subsystem top: wires the baud tick generator to the serializer.
// Note: rst_n is an active-high synchronous reset despite its name.
module uart_tx_baud_top
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             tx_start,
    input  logic [7:0]       tx_data,
    output logic             tx_line,
    output logic             tx_busy,
    output logic             baud_tick_16x,
    output logic             baud_tick_1x
);

    logic w_tick_16x;
    logic w_tick_1x;

    uart_baud_gen #(
        .P_DIV_W      (DIV_W),
        .P_OVERSAMPLE (OVERSAMPLE)
    ) u_baud_gen (
        .clk        (clk),
        .i_srst     (rst_n),
        .i_baud_div (baud_div),
        .o_tick_16x (w_tick_16x),
        .o_tick_1x  (w_tick_1x)
    );

    uart_tx_fsm #(
        .P_DATA_BITS (DATA_BITS)
    ) u_tx_fsm (
        .clk        (clk),
        .i_srst     (rst_n),
        .i_tick_1x  (w_tick_1x),
        .i_tx_start (tx_start),
        .i_tx_data  (tx_data),
        .o_tx_line  (tx_line),
        .o_tx_busy  (tx_busy)
    );

    assign baud_tick_16x = w_tick_16x;
    assign baud_tick_1x  = w_tick_1x;

endmodule

// File: tb/tb_uart_tx_baud_top.sv
// Directed testbench for uart_tx_baud_top: reset, tick rates, 8N1 framing,
// busy-ignore, back-to-back frames and mid-frame abort.
module tb_uart_tx_baud_top;

    logic        clk;
    logic        rst_n;
    logic [15:0] baud_div;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_line;
    logic        tx_busy;
    logic        tick16;
    logic        tick1x;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_baud_top dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .baud_div      (baud_div),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_line       (tx_line),
        .tx_busy       (tx_busy),
        .baud_tick_16x (tick16),
        .baud_tick_1x  (tick1x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends on its own.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    // Checks one full frame starting from the current negedge. Every bit must
    // hold its value for exactly 80 clocks (baud_div=5). mode 1 injects a
    // tx_start with a different byte mid-frame; mode 2 releases tx_start mid-frame.
    task automatic check_frame(input logic [7:0] d, input int mode, output int gap);
        logic eb;
        int   n;
        gap = 0;
        while (tx_line !== 1'b0 && gap < 200) begin
            @(negedge clk);
            gap++;
        end
        check("frame_start_seen", {31'd0, tx_line}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      eb = 1'b0;
            else if (k == 9) eb = 1'b1;
            else             eb = d[k-1];
            n = 0;
            for (int c = 0; c < 80; c++) begin
                if (tx_line === eb) n++;
                if (mode == 1 && k == 3 && c == 10) begin
                    tx_start = 1'b1;
                    tx_data  = 8'h3C;
                end
                if (mode == 1 && k == 3 && c == 14) tx_start = 1'b0;
                if (mode == 2 && k == 3 && c == 0)  tx_start = 1'b0;
                if (k == 9 && c == 79) check("busy_end_of_stop", {31'd0, tx_busy}, 32'd1);
                @(negedge clk);
            end
            check($sformatf("frame_%02h_bit%0d_clks", d, k), n, 32'd80);
        end
        check("busy_drop", {31'd0, tx_busy}, 32'd0);
    endtask

    initial begin
        int n;
        int gap;
        rst_n    = 1'b1;
        baud_div = 16'd5;
        tx_start = 1'b0;
        tx_data  = 8'h00;

        // Reset held for 3 clocks
        repeat (3) begin
            @(negedge clk);
            check("rst_line",   {31'd0, tx_line}, 32'd1);
            check("rst_busy",   {31'd0, tx_busy}, 32'd0);
            check("rst_tick16", {31'd0, tick16},  32'd0);
            check("rst_tick1x", {31'd0, tick1x},  32'd0);
        end
        rst_n = 1'b0;

        // 16x tick period at baud_div=5
        n = 0;
        while (!tick16 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t16_found", {31'd0, tick16}, 32'd1);
        repeat (3) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!tick16 && n < 50);
            check("t16_period", n, 32'd5);
        end

        // 1x tick period and coincidence with the 16x tick
        n = 0;
        while (!tick1x && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t1x_found",    {31'd0, tick1x}, 32'd1);
        check("t1x_with_t16", {31'd0, tick16}, 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick1x && n < 200);
        check("t1x_period", n, 32'd80);

        // Divisor 0 and 1 both tick every clock
        for (int d = 0; d < 2; d++) begin
            baud_div = 16'(d);
            @(negedge clk);
            @(negedge clk);
            n = 0;
            repeat (4) begin
                if (tick16) n++;
                @(negedge clk);
            end
            check($sformatf("t16_every_clk_div%0d", d), n, 32'd4);
        end
        baud_div = 16'd5;
        @(negedge clk);

        // Frame A5 with a 2-clock start pulse and a busy-time start to ignore
        tx_data  = 8'hA5;
        tx_start = 1'b1;
        @(negedge clk);
        check("busy_rise",      {31'd0, tx_busy}, 32'd1);
        check("line_idle_wait", {31'd0, tx_line}, 32'd1);
        @(negedge clk);
        tx_start = 1'b0;
        check_frame(8'hA5, 1, gap);

        n = 0;
        repeat (200) begin
            if (tx_line === 1'b1 && tx_busy === 1'b0) n++;
            @(negedge clk);
        end
        check("no_second_frame", n, 32'd200);

        // Back-to-back frames with tx_start held high
        tx_data  = 8'h5A;
        tx_start = 1'b1;
        check_frame(8'h5A, 0, gap);
        check_frame(8'h5A, 2, gap);
        check("b2b_gap_le_bit", {31'd0, (gap <= 80)}, 32'd1);
        n = 0;
        repeat (200) begin
            if (tx_line === 1'b1 && tx_busy === 1'b0) n++;
            @(negedge clk);
        end
        check("b2b_no_third_frame", n, 32'd200);

        // Abort during DATA, then a fresh 00 frame
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        n = 0;
        while (tx_line !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_frame_started", {31'd0, tx_line}, 32'd0);
        repeat (200) @(negedge clk);
        check("abort_pre_line", {31'd0, tx_line}, 32'd0);
        check("abort_pre_busy", {31'd0, tx_busy}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_line",   {31'd0, tx_line}, 32'd1);
        check("abort_busy",   {31'd0, tx_busy}, 32'd0);
        check("abort_tick16", {31'd0, tick16},  32'd0);
        rst_n = 1'b0;

        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        check("post_abort_busy", {31'd0, tx_busy}, 32'd1);
        tx_start = 1'b0;
        check_frame(8'h00, 0, gap);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
